wait_state_data_mem: RTL
========================

Name: wait_state_data_mem

Overview:
- Multi-cycle data memory responder. It answers the memory stage's read/write request handshake (re/we, addr, data, size → data_ready/write_ready).
- Models a RAM with programmable wait states, so the pipeline's memory-hazard stall path is exercised.
- Performs little-endian byte/halfword/word accesses and flags misaligned or out-of-range requests.
- Sits below the memory stage for addresses below the MMIO window.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two ≥ 4.
- READ_LATENCY, 2, cycles from request acceptance to o_data_ready pulse; ≥ 1.
- WRITE_LATENCY, 1, cycles from request acceptance to o_write_ready pulse; ≥ 1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_re  in  1  read request.
- i_we  in  1  write request.
- i_addr  in  32  byte address.
- i_data  in  32  write data; byte in [7:0], halfword in [15:0].
- i_mem_size  in  2  access size: 0=BYTE, 1=HWORD, 2=WORD, 3=reserved (treated as error).
- o_data  out  32  read data, zero-extended and right-aligned; the initiator applies sign extension.
- o_data_ready  out  1  one-cycle pulse: read complete, o_data valid.
- o_write_ready  out  1  one-cycle pulse: write complete.
- o_busy  out  1  high while a request is in flight.
- o_err  out  1  one-cycle pulse coincident with the ready pulse when the access was rejected.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rstn is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - o_data = 0; o_data_ready, o_write_ready, o_busy and o_err = 0.
  - Latency counter = 0.
  - Memory array is not reset; contents are undefined until written.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE, request acceptance:
  - A request is accepted on an edge where i_re or i_we is high.
  - On acceptance, latch addr, data and size; load the counter with LATENCY-1; set o_busy=1.
  - i_we=1 → WRITE_WAIT. Write has priority when i_re and i_we are both high; the read is dropped.
- READ_WAIT / WRITE_WAIT:
  - Requests are ignored; the initiator holds or drops them, and they are not queued.
  - The counter decrements each cycle.
  - At the edge where the counter is 0:
    - Perform the access.
    - Pulse the matching ready for exactly one cycle and raise o_err if the access is rejected.
    - Clear o_busy and return to IDLE.
  - Latency therefore equals exactly LATENCY cycles: the ready pulse is visible LATENCY cycles after the accepting edge.
- Back-to-back: a new request may be accepted on the edge immediately after the ready-pulse cycle (i.e. while in IDLE with ready high). No dead cycle is required beyond that.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
  - Storage is little-endian: byte lane n is bits [8n+7:8n].
- Read result:
  - BYTE returns the selected lane in [7:0].
  - HWORD returns lanes {addr[1]*2+1, addr[1]*2} in [15:0].
  - WORD returns the full word.
  - Upper bits are 0 for BYTE and HWORD.
- Write: only the addressed lanes are modified, using byte enables derived from size and addr[1:0]; other lanes are preserved.
- Error / rejection. A request is rejected if any of the following holds:
  - HWORD with addr[0]=1.
  - WORD with addr[1:0]≠0.
  - size=3.
  - addr ≥ DEPTH_WORDS*4.
- Rejected read: o_data=0, o_err=1, o_data_ready still pulses so the initiator never deadlocks.
- Rejected write: memory unchanged, o_err=1, o_write_ready pulses.
- o_data hold rule: o_data holds its last value until the next read completion; writes do not change o_data.
- Reset mid-operation: the transaction is aborted immediately, no ready pulse is produced, and an uncommitted write is never applied. Memory state is otherwise preserved.

Test Plan:
- Reset, then WORD write 0xDEADBEEF @0x10 (WRITE_LATENCY=1) → o_write_ready pulses 1 cycle after acceptance, o_busy high only in between; WORD read @0x10 → o_data_ready exactly 2 cycles after acceptance, o_data=0xDEADBEEF.
- Sub-word access:
  - BYTE write 0x55 @0x11 over 0xDEADBEEF → WORD read @0x10 = 0xDEAD55EF.
  - HWORD read @0x12 = 0x0000DEAD.
  - BYTE read @0x13 = 0x000000DE.
- Misaligned: HWORD write 0x1234 @0x21, WORD read @0x22, read with size=3 → each yields a ready pulse with o_err=1; @0x21 data is unchanged; o_data=0 on the rejected reads.
- Out of range: WORD read @0x100 with DEPTH_WORDS=64 → o_data_ready + o_err, o_data=0.
- Contention:
  - i_re and i_we both high → write performed, only o_write_ready pulses.
  - A new i_re asserted during READ_WAIT is ignored and produces no extra pulse.
  - A request on the edge after the ready pulse is accepted.
- Abort: assert i_rstn=0 during WRITE_WAIT of 0xCAFEF00D @0x30 (WRITE_LATENCY=3) → no o_write_ready pulse, and a read @0x30 after reset returns the prior value.

Source files
------------

// File: rtl/wait_state_data_mem_if.sv
// Request/response bundle between the memory stage and the wait-state data RAM.
// The master drives requests; the slave returns data, ready pulses and error.
interface wait_state_data_mem_if;
  logic        i_re;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_mem_size;
  logic [31:0] o_data;
  logic        o_data_ready;
  logic        o_write_ready;
  logic        o_busy;
  logic        o_err;

  modport master (
    output i_re, i_we, i_addr, i_data, i_mem_size,
    input  o_data, o_data_ready, o_write_ready, o_busy, o_err
  );

  modport slave (
    input  i_re, i_we, i_addr, i_data, i_mem_size,
    output o_data, o_data_ready, o_write_ready, o_busy, o_err
  );
endinterface

// File: rtl/wait_state_data_mem.sv
// Data RAM with programmable read/write wait states and little-endian sub-word access.
// Misaligned, reserved-size and out-of-range accesses complete with o_err instead of stalling.
module wait_state_data_mem #(
  parameter int DEPTH_WORDS   = 64,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input logic                  i_clk,
  input logic                  i_rstn,
  wait_state_data_mem_if.slave mem
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        rdy_q;
  logic        wrdy_q;
  logic        busy_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_d;
  logic [1:0]    lane_d;
  logic [31:0]   word_d;
  logic          done_d;
  logic          bad_d;
  logic          commit_d;
  logic [3:0]    be_d;
  logic [31:0]   rd_d;
  logic [31:0]   wd_d;

  assign idx_d    = addr_q[AW+1:2];
  assign lane_d   = addr_q[1:0];
  assign word_d   = mem_q[idx_d];
  assign done_d   = (cnt_q == '0);
  // State is forced to IDLE asynchronously, so an aborted write can never commit.
  assign commit_d = (state_q == WRITE_WAIT) && done_d && !bad_d;

  always_comb begin
    bad_d = |addr_q[31:AW+2];
    case (size_q)
      2'd1:    if (addr_q[0]) bad_d = 1'b1;
      2'd2:    if (addr_q[1:0] != 2'd0) bad_d = 1'b1;
      2'd3:    bad_d = 1'b1;
      default: ;
    endcase
  end

  // Write data is replicated across lanes so byte enables alone select the target lanes.
  always_comb begin
    rd_d = '0;
    be_d = '0;
    wd_d = wdata_q;
    case (size_q)
      2'd0: begin
        rd_d = {24'h0, word_d[{lane_d, 3'b000} +: 8]};
        be_d = 4'b0001 << lane_d;
        wd_d = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        rd_d = {16'h0, (addr_q[1] ? word_d[31:16] : word_d[15:0])};
        be_d = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{wdata_q[15:0]}};
      end
      2'd2: begin
        rd_d = word_d;
        be_d = 4'b1111;
      end
      default: ;
    endcase
    if (bad_d) begin
      rd_d = '0;
      be_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (commit_d && be_d[n]) mem_q[idx_d][8*n +: 8] <= wd_d[8*n +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      wrdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      wrdy_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem.i_we || mem.i_re) begin
            addr_q  <= mem.i_addr;
            wdata_q <= mem.i_data;
            size_q  <= mem.i_mem_size;
            busy_q  <= 1'b1;
            if (mem.i_we) begin
              state_q <= WRITE_WAIT;
              cnt_q   <= CW'(WRITE_LATENCY - 1);
            end else begin
              state_q <= READ_WAIT;
              cnt_q   <= CW'(READ_LATENCY - 1);
            end
          end
        end
        READ_WAIT: begin
          if (done_d) begin
            rdata_q <= rd_d;
            rdy_q   <= 1'b1;
            err_q   <= bad_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WRITE_WAIT: begin
          if (done_d) begin
            wrdy_q  <= 1'b1;
            err_q   <= bad_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.o_data        = rdata_q;
  assign mem.o_data_ready  = rdy_q;
  assign mem.o_write_ready = wrdy_q;
  assign mem.o_busy        = busy_q;
  assign mem.o_err         = err_q;

endmodule
